// File: rtl/lib_switch_allocator.sv
// -----------------------------------------------------------------------------
// lib_switch_allocator
//
// Per-output round-robin switch allocator for an N-input x M-output packet
// crossbar. Each input presents at most one (one-hot) output request per
// cycle; every output independently picks one requesting input, starting its
// search at a registered round-robin pointer. The result is returned as
// per-input grants and as per-output one-hot crossbar select vectors. Grants are
// combinational (zero latency) from the requests, the enables and the
// registered state. Arbitration state updates on the rising clock edge.
//
// Optional feature (compile-time macro LIB_SWITCH_ALLOC_LOCK_EN):
//   Wormhole output locking. A granted non-tail flit locks its output to the
//   winning input until that input's tail flit is granted. Without the macro,
//   i_tail is ignored and every flit is arbitrated on its own.
//
// Parameters:
//   N        number of inputs (input buffers / crossbar inputs)
//   M        number of outputs (crossbar outputs)
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset; forces o_grant/o_sel to zero
//   i_req    [0:N-1][0:M-1] per-input one-hot output request; bit [j][i] set
//            means input j requests output i; rows with more than one bit set
//            are illegal and ignored
//   i_tail   [0:N-1] flit presented by input j is a packet tail
//            (only used with LIB_SWITCH_ALLOC_LOCK_EN)
//   i_en     [0:M-1] output i can accept a flit this cycle
//   o_grant  [0:N-1] input j wins an output and its flit transfers this cycle
//   o_sel    [0:M-1][0:N-1] per-output one-hot input select for the crossbar;
//            all-zero means the output is idle
// -----------------------------------------------------------------------------
module lib_switch_allocator #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:N-1][0:M-1] i_req,
    input  logic [0:N-1]        i_tail,
    input  logic [0:M-1]        i_en,
    output logic [0:N-1]        o_grant,
    output logic [0:M-1][0:N-1] o_sel
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    typedef logic [PtrW-1:0] ptr_t;

    // Round-robin successor of an input index, wrapping N-1 back to 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(N - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ptr_t ptr_q [M];
    ptr_t ptr_d [M];

`ifdef LIB_SWITCH_ALLOC_LOCK_EN
    logic [0:M-1] lock_vld_q;
    logic [0:M-1] lock_vld_d;
    ptr_t         lock_own_q [M];
    ptr_t         lock_own_d [M];
`else
    // Tail flags carry no meaning when outputs are never locked.
    logic         unused_tail;
    assign unused_tail = ^i_tail;
`endif

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic [0:N-1]        legal;
    logic [0:M-1][0:N-1] cand;

    always_comb begin
        legal = '0;
        cand  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            // A multi-hot row is a malformed request: treat the input as idle.
            legal[j] = $onehot(i_req[j]);
        end
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                cand[i][j] = legal[j] & i_req[j][i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-output arbitration
    // -------------------------------------------------------------------------
    logic [0:M-1] win_vld;
    ptr_t         win_idx [M];
    logic [0:M-1] gnt_vld;
    logic [PtrW:0] scan;

    always_comb begin
        win_vld = '0;
        gnt_vld = '0;
        scan    = '0;
        for (int unsigned i = 0; i < M; i++) begin
            win_idx[i] = '0;
            // First candidate at or after the pointer, modulo N.
            for (int unsigned k = 0; k < N; k++) begin
                scan = {1'b0, ptr_q[i]} + (PtrW + 1)'(k);
                if (scan >= (PtrW + 1)'(N)) begin
                    scan = scan - (PtrW + 1)'(N);
                end
                if (!win_vld[i] && cand[i][scan[PtrW-1:0]]) begin
                    win_vld[i] = 1'b1;
                    win_idx[i] = scan[PtrW-1:0];
                end
            end
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
            // A locked output only ever serves its owner; everyone else waits.
            if (lock_vld_q[i]) begin
                win_vld[i] = cand[i][lock_own_q[i]];
                win_idx[i] = lock_own_q[i];
            end
`endif
            gnt_vld[i] = win_vld[i] & i_en[i] & ~reset;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_sel   = '0;
        o_grant = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (gnt_vld[i]) begin
                o_sel[i][win_idx[i]] = 1'b1;
            end
        end
        // Each input requests at most one output, so this OR never merges
        // two grants for the same input.
        for (int unsigned i = 0; i < M; i++) begin
            o_grant = o_grant | o_sel[i];
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            ptr_d[i] = ptr_q[i];
        end
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
        lock_vld_d = lock_vld_q;
        for (int unsigned i = 0; i < M; i++) begin
            lock_own_d[i] = lock_own_q[i];
        end
`endif
        for (int unsigned i = 0; i < M; i++) begin
            if (gnt_vld[i]) begin
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
                if (i_tail[win_idx[i]]) begin
                    // Tail (or single-flit packet): release and move on.
                    lock_vld_d[i] = 1'b0;
                    ptr_d[i]      = ptr_inc(win_idx[i]);
                end else begin
                    // Head/body: hold the output, pointer frozen until tail.
                    lock_vld_d[i] = 1'b1;
                    lock_own_d[i] = win_idx[i];
                end
`else
                ptr_d[i] = ptr_inc(win_idx[i]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < M; i++) begin
                ptr_q[i] <= '0;
            end
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
            lock_vld_q <= '0;
            for (int unsigned i = 0; i < M; i++) begin
                lock_own_q[i] <= '0;
            end
`endif
        end else begin
            for (int unsigned i = 0; i < M; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
`ifdef LIB_SWITCH_ALLOC_LOCK_EN
            lock_vld_q <= lock_vld_d;
            for (int unsigned i = 0; i < M; i++) begin
                lock_own_q[i] <= lock_own_d[i];
            end
`endif
        end
    end

endmodule
